// File: rtl/tile_buffer_pkg.sv
// tile_buffer_pkg: shared widths and read FSM encoding
// for the ping-pong tile buffer scheduler.
package tile_buffer_pkg;

    localparam int AW         = 10;
    localparam int DW         = 128;
    localparam int HALF_DEPTH = 2 ** (AW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/tile_buffer_skew.sv
// tile_buffer_skew: per-lane read enable/address skew chain
// plus BRAM latency delay of the enables into dout_vld.
module tile_buffer_skew
    import tile_buffer_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               en_in,
    input  logic [AW-1:0]      addr_in,
    output logic [SIZE-1:0]    enb,
    output logic [SIZE*AW-1:0] addrb,
    output logic [SIZE-1:0]    dout_vld
);

    logic [SIZE-1:0] en_q;
    logic [AW-1:0]   addr_q [SIZE];
    logic [SIZE-1:0] vld_q  [RD_LAT];

    // lane 0 registers the request; lane i copies lane i-1
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            en_q[0]   <= en_in;
            addr_q[0] <= addr_in;
            for (int i = 1; i < SIZE; i++) begin
                en_q[i]   <= en_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    // enables delayed by the BRAM read latency
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= en_q;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // flatten lane addresses onto the packed port
    always_comb begin
        addrb = '0;
        for (int i = 0; i < SIZE; i++) begin
            addrb[i*AW +: AW] = addr_q[i];
        end
    end

    assign enb      = en_q;
    assign dout_vld = vld_q[RD_LAT-1];

endmodule

// File: rtl/tile_buffer_sched.sv
// tile_buffer_sched: ping-pong scheduler for the banked tile
// buffer, one shared write stream and SIZE skewed read lanes.
module tile_buffer_sched
    import tile_buffer_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DW-1:0]      wr_data,
    input  logic               wr_last,
    input  logic               rd_start,
    output logic               rd_busy,
    output logic               rd_done,
    output logic [1:0]         half_full,
    output logic               wea,
    output logic [AW-1:0]      addra,
    output logic [DW-1:0]      dina,
    output logic [SIZE-1:0]    enb,
    output logic [SIZE*AW-1:0] addrb,
    output logic [SIZE-1:0]    dout_vld
);

    localparam int PW  = AW - 1;
    localparam int DCW = $clog2(SIZE + RD_LAT + 1);

    logic          wr_half;
    logic          rd_half;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] len [2];
    logic          hs;
    logic          wr_end;
    logic [1:0]    set_full;
    logic [1:0]    clr_full;

    rd_state_e     state;
    rd_state_e     state_nxt;
    logic [PW-1:0] r;
    logic [DCW-1:0] dcnt;
    logic          run;
    logic          done_nxt;

    assign wr_ready = !half_full[wr_half];
    assign hs       = wr_valid && wr_ready;
    assign wr_end   = hs && (wr_last || wr_ptr == PW'(HALF_DEPTH - 1));
    assign rd_busy  = (state != ST_IDLE);

    assign set_full[0] = wr_end && !wr_half;
    assign set_full[1] = wr_end && wr_half;

    // write port register, pointer and tile length capture
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wea     <= 1'b0;
            addra   <= '0;
            dina    <= '0;
            wr_ptr  <= '0;
            wr_half <= 1'b0;
            len[0]  <= '0;
            len[1]  <= '0;
        end else begin
            wea <= hs;
            if (hs) begin
                addra <= {wr_half, wr_ptr};
                dina  <= wr_data;
                if (wr_end) begin
                    len[wr_half] <= AW'(wr_ptr) + AW'(1);
                    wr_half      <= !wr_half;
                    wr_ptr       <= '0;
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
        end
    end

    // writer and reader always touch different halves
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            half_full <= 2'b00;
        end else begin
            half_full <= (half_full | set_full) & ~clr_full;
        end
    end

    // read FSM next state and per-cycle controls
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        done_nxt  = 1'b0;
        clr_full  = 2'b00;
        unique case (state)
            ST_IDLE: begin
                if (rd_start) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (half_full[rd_half]) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                run = 1'b1;
                if (AW'(r) + AW'(1) == len[rd_half]) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // one extra cycle covers the registered lane-0 enable
                if (dcnt == DCW'(SIZE + RD_LAT - 1)) begin
                    state_nxt         = ST_IDLE;
                    done_nxt          = 1'b1;
                    clr_full[rd_half] = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // read FSM state, row and drain counters, half select
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            r       <= '0;
            dcnt    <= '0;
            rd_half <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_done <= done_nxt;
            if (run && state_nxt == ST_RUN) begin
                r <= r + PW'(1);
            end else begin
                r <= '0;
            end
            if (state == ST_DRAIN && state_nxt == ST_DRAIN) begin
                dcnt <= dcnt + DCW'(1);
            end else begin
                dcnt <= '0;
            end
            if (done_nxt) rd_half <= !rd_half;
        end
    end

    tile_buffer_skew #(
        .SIZE   (SIZE),
        .RD_LAT (RD_LAT)
    ) u_skew (
        .clock    (clock),
        .rst_n    (rst_n),
        .en_in    (run),
        .addr_in  ({rd_half, r}),
        .enb      (enb),
        .addrb    (addrb),
        .dout_vld (dout_vld)
    );

endmodule

// File: tb/tb_tile_buffer_sched.sv
// tb_tile_buffer_sched: directed self-checking bench for
// the ping-pong tile buffer scheduler.
module tb_tile_buffer_sched;
    import tile_buffer_pkg::*;

    localparam int SIZE   = 8;
    localparam int RD_LAT = 1;

    logic               clock;
    logic               rst_n;
    logic               wr_valid;
    logic               wr_ready;
    logic [DW-1:0]      wr_data;
    logic               wr_last;
    logic               rd_start;
    logic               rd_busy;
    logic               rd_done;
    logic [1:0]         half_full;
    logic               wea;
    logic [AW-1:0]      addra;
    logic [DW-1:0]      dina;
    logic [SIZE-1:0]    enb;
    logic [SIZE*AW-1:0] addrb;
    logic [SIZE-1:0]    dout_vld;

    int errors = 0;
    int checks = 0;

    tile_buffer_sched #(
        .SIZE   (SIZE),
        .RD_LAT (RD_LAT)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .rd_start  (rd_start),
        .rd_busy   (rd_busy),
        .rd_done   (rd_done),
        .half_full (half_full),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .enb       (enb),
        .addrb     (addrb),
        .dout_vld  (dout_vld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] row(input int k);
        return {96'h0, 32'hC0DE_0000 | 32'(k)};
    endfunction

    function automatic logic [AW-1:0] lane_addr(input logic [SIZE*AW-1:0] v,
                                                 input int i);
        return v[i*AW +: AW];
    endfunction

    task automatic do_reset();
        wr_valid = 0; wr_last = 0; wr_data = '0; rd_start = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        wr_valid = 0; wr_last = 0; wr_data = '0; rd_start = 0;
        rst_n = 0;
        tick(); tick();
        checks++;
        if (wea !== 1'b0 || addra !== '0 || dina !== '0) begin
            errors++;
            $display("FAIL reset_wr: wea=%b addra=%0d dina=%h want 0", wea, addra, dina);
        end
        checks++;
        if (enb !== '0 || addrb !== '0 || dout_vld !== '0) begin
            errors++;
            $display("FAIL reset_rd: enb=%h addrb=%h vld=%h want 0", enb, addrb, dout_vld);
        end
        checks++;
        if (half_full !== 2'b00 || rd_busy !== 1'b0 || rd_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: hf=%b busy=%b done=%b want 0", half_full, rd_busy, rd_done);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: wr_ready=%b want 1", wr_ready);
        end
        rst_n = 1;
        tick();
        checks++;
        if (rd_busy !== 1'b0 || enb !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b enb=%h want 0", rd_busy, enb);
        end
    endtask

    task automatic test_write4();
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1; wr_data = row(k); wr_last = (k == 3);
            tick();
            checks++;
            if (wea !== 1'b1 || addra !== AW'(k) || dina !== row(k)) begin
                errors++;
                $display("FAIL write4_row%0d: wea=%b addra=%0d dina=%h want 1 %0d %h",
                         k, wea, addra, dina, k, row(k));
            end
        end
        wr_valid = 0; wr_last = 0;
        checks++;
        if (half_full !== 2'b01 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write4_full: hf=%b ready=%b want 01 1", half_full, wr_ready);
        end
        tick();
        checks++;
        if (wea !== 1'b0) begin
            errors++;
            $display("FAIL write4_idle: wea=%b want 0", wea);
        end
    endtask

    task automatic test_replay4();
        logic [SIZE-1:0] exp_en;
        logic [SIZE-1:0] exp_vld;
        logic            exp_done;
        logic            exp_busy;
        logic [1:0]      exp_hf;
        rd_start = 1;
        tick();
        rd_start = 0;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) begin
                rd_start = (c == 6);
                tick();
                rd_start = 0;
            end
            for (int i = 0; i < SIZE; i++) begin
                exp_en[i]  = (c >= 2 + i && c <= 5 + i);
                exp_vld[i] = (c >= 3 + i && c <= 6 + i);
            end
            exp_done = (c == 14);
            exp_busy = (c <= 13);
            exp_hf   = (c < 14) ? 2'b01 : 2'b00;
            checks++;
            if (enb !== exp_en) begin
                errors++;
                $display("FAIL replay_enb c%0d: got %b want %b", c, enb, exp_en);
            end
            checks++;
            if (dout_vld !== exp_vld) begin
                errors++;
                $display("FAIL replay_vld c%0d: got %b want %b", c, dout_vld, exp_vld);
            end
            for (int i = 0; i < SIZE; i++) begin
                if (exp_en[i]) begin
                    checks++;
                    if (lane_addr(addrb, i) !== AW'(c - 2 - i)) begin
                        errors++;
                        $display("FAIL replay_addr c%0d lane%0d: got %0d want %0d",
                                 c, i, lane_addr(addrb, i), c - 2 - i);
                    end
                end
            end
            checks++;
            if (rd_done !== exp_done || rd_busy !== exp_busy) begin
                errors++;
                $display("FAIL replay_ctl c%0d: done=%b busy=%b want %b %b",
                         c, rd_done, rd_busy, exp_done, exp_busy);
            end
            checks++;
            if (half_full !== exp_hf) begin
                errors++;
                $display("FAIL replay_hf c%0d: got %b want %b", c, half_full, exp_hf);
            end
        end
    endtask

    task automatic test_fill_both();
        int  c;
        logic seen;
        for (int k = 0; k < HALF_DEPTH; k++) begin
            wr_valid = 1; wr_data = row(k); wr_last = 0;
            tick();
            checks++;
            if (wea !== 1'b1 || addra !== AW'(k)) begin
                errors++;
                $display("FAIL fill_row%0d: wea=%b addra=%0d want 1 %0d", k, wea, addra, k);
            end
        end
        checks++;
        if (half_full !== 2'b01) begin
            errors++;
            $display("FAIL fill_auto_wrap: hf=%b want 01", half_full);
        end
        wr_data = row(999); wr_last = 1;
        tick();
        checks++;
        if (addra !== AW'(512) || half_full !== 2'b11) begin
            errors++;
            $display("FAIL fill_half1: addra=%0d hf=%b want 512 11", addra, half_full);
        end
        wr_data = {4{32'hDEAD_BEEF}}; wr_last = 1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_stall: wr_ready=%b want 0", wr_ready);
        end
        rd_start = 1;
        tick();
        rd_start = 0;
        c = 0;
        seen = 0;
        while (!seen && c < 700) begin
            tick();
            c++;
            if (rd_done === 1'b1) begin
                seen = 1;
                checks++;
                if (c != 522 || wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_done: cycle=%0d ready=%b want 522 1", c, wr_ready);
                end
            end else begin
                checks++;
                if (wr_ready !== 1'b0 || wea !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_hold c%0d: ready=%b wea=%b want 0 0", c, wr_ready, wea);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL fill_timeout: rd_done=0 want 1 within 700 cycles");
        end
        tick();
        wr_valid = 0; wr_last = 0;
        checks++;
        if (wea !== 1'b1 || addra !== '0 || dina !== {4{32'hDEAD_BEEF}}) begin
            errors++;
            $display("FAIL fill_release: wea=%b addra=%0d dina=%h want 1 0 deadbeef",
                     wea, addra, dina);
        end
    endtask

    task automatic test_wait_empty();
        int   n;
        logic seen;
        rd_start = 1;
        tick();
        rd_start = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            checks++;
            if (rd_busy !== 1'b1 || enb !== '0) begin
                errors++;
                $display("FAIL wait_idle c%0d: busy=%b enb=%h want 1 0", c, rd_busy, enb);
            end
        end
        wr_valid = 1; wr_data = row(20); wr_last = 0;
        tick();
        checks++;
        if (half_full !== 2'b00 || enb !== '0) begin
            errors++;
            $display("FAIL wait_row0: hf=%b enb=%h want 00 0", half_full, enb);
        end
        wr_data = row(21); wr_last = 1;
        tick();
        wr_valid = 0; wr_last = 0;
        checks++;
        if (half_full !== 2'b01 || enb !== '0) begin
            errors++;
            $display("FAIL wait_set: hf=%b enb=%h want 01 0", half_full, enb);
        end
        tick();
        checks++;
        if (enb !== '0 || rd_busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_run: enb=%h busy=%b want 0 1", enb, rd_busy);
        end
        tick();
        checks++;
        if (enb !== 8'h01 || lane_addr(addrb, 0) !== '0) begin
            errors++;
            $display("FAIL wait_first: enb=%h a0=%0d want 01 0", enb, lane_addr(addrb, 0));
        end
        tick();
        checks++;
        if (enb !== 8'h03 || lane_addr(addrb, 0) !== AW'(1) || lane_addr(addrb, 1) !== '0) begin
            errors++;
            $display("FAIL wait_second: enb=%h a0=%0d a1=%0d want 03 1 0",
                     enb, lane_addr(addrb, 0), lane_addr(addrb, 1));
        end
        n = 0;
        seen = 0;
        while (!seen && n < 30) begin
            tick();
            n++;
            if (rd_done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != 9) begin
            errors++;
            $display("FAIL wait_done: seen=%b after %0d want 1 after 9", seen, n);
        end
    endtask

    task automatic test_concurrent();
        logic [AW-1:0] la;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1; wr_data = row(k); wr_last = (k == 3);
            tick();
        end
        wr_valid = 0; wr_last = 0;
        rd_start = 1;
        tick();
        rd_start = 0;
        for (int k = 0; k < 14; k++) begin
            wr_valid = 1; wr_data = row(100 + k); wr_last = (k == 13);
            tick();
            checks++;
            if (wea !== 1'b1 || addra !== AW'(512 + k)) begin
                errors++;
                $display("FAIL conc_wr%0d: wea=%b addra=%0d want 1 %0d", k, wea, addra, 512 + k);
            end
            for (int i = 0; i < SIZE; i++) begin
                la = lane_addr(addrb, i);
                if (enb[i] === 1'b1) begin
                    checks++;
                    if (la[AW-1] === addra[AW-1]) begin
                        errors++;
                        $display("FAIL conc_overlap k%0d lane%0d: rd=%0d wr=%0d want other half",
                                 k, i, la, addra);
                    end
                end
            end
            if (k == 1) begin
                checks++;
                if (enb[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL conc_active: enb0=%b want 1", enb[0]);
                end
            end
            checks++;
            if (k == 13) begin
                if (rd_done !== 1'b1 || half_full !== 2'b10) begin
                    errors++;
                    $display("FAIL conc_same_cycle: done=%b hf=%b want 1 10", rd_done, half_full);
                end
            end else if (rd_done !== 1'b0 || half_full !== 2'b01) begin
                errors++;
                $display("FAIL conc_flags k%0d: done=%b hf=%b want 0 01", k, rd_done, half_full);
            end
        end
        wr_valid = 0; wr_last = 0;
        tick();
        checks++;
        if (rd_done !== 1'b0 || half_full !== 2'b10 || wea !== 1'b0) begin
            errors++;
            $display("FAIL conc_after: done=%b hf=%b wea=%b want 0 10 0", rd_done, half_full, wea);
        end
    endtask

    task automatic test_reset_mid();
        rd_start = 1;
        tick();
        rd_start = 0;
        tick();
        tick();
        checks++;
        if (enb[0] !== 1'b1 || rd_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: enb0=%b busy=%b want 1 1", enb[0], rd_busy);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (wea !== 1'b0 || addra !== '0 || dina !== '0 || enb !== '0 ||
            addrb !== '0 || dout_vld !== '0) begin
            errors++;
            $display("FAIL mid_ports: wea=%b addra=%0d enb=%h vld=%h want 0",
                     wea, addra, enb, dout_vld);
        end
        checks++;
        if (half_full !== 2'b00 || rd_busy !== 1'b0 || rd_done !== 1'b0 ||
            wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_flags: hf=%b busy=%b done=%b ready=%b want 00 0 0 1",
                     half_full, rd_busy, rd_done, wr_ready);
        end
        tick();
        rst_n = 1;
        tick();
        tick();
        checks++;
        if (enb !== '0 || rd_busy !== 1'b0 || half_full !== 2'b00) begin
            errors++;
            $display("FAIL mid_after: enb=%h busy=%b hf=%b want 0 0 00", enb, rd_busy, half_full);
        end
    endtask

    initial begin
        test_reset();
        test_write4();
        test_replay4();
        do_reset();
        test_fill_both();
        do_reset();
        test_wait_empty();
        do_reset();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
